// File: rtl/serial_sub.sv
// serial_sub: bit-serial subtractor, diff = a - b - bin over WIDTH cycles, LSB first
//
// One full-subtractor cell and a registered borrow. The operands are loaded
// through a start/ready handshake. A one-cycle done pulse marks the parallel result.
//
// Optional feature macro: SERIAL_SUB_OVF_EN (adds ovf_o, the signed overflow flag)
//
// Ports:
//   clk      system clock, rising edge
//   rst_n    asynchronous active-low reset
//   start_i  request, sampled only while ready_o=1
//   a_i      minuend, captured on the accepting edge
//   b_i      subtrahend, captured on the accepting edge
//   bin_i    borrow-in, captured on the accepting edge
//   ready_o  idle, start will be accepted
//   done_o   one-cycle pulse, result outputs valid
//   diff_o   a - b - bin modulo 2^WIDTH
//   bout_o   borrow-out, 1 iff a < b + bin (unsigned)
//   zero_o   1 iff diff_o == 0
//   ovf_o    signed overflow (only with SERIAL_SUB_OVF_EN)
module serial_sub #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             bin_i,
    output logic             ready_o,
    output logic             done_o,
    output logic [WIDTH-1:0] diff_o,
    output logic             bout_o,
    output logic             zero_o
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf_o
`endif
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q, b_q, r_q, diff_q;
    logic [CW-1:0]    cnt_q;
    logic             br_q, ready_q, done_q, bout_q, zero_q;
    logic             bit_d, br_d;
    logic [WIDTH-1:0] res_d;

    // full-subtractor cell; the new bit enters at the MSB so the LSB lands at bit 0 after WIDTH shifts
    assign bit_d = a_q[0] ^ b_q[0] ^ br_q;
    assign br_d  = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
    assign res_d = {bit_d, r_q[WIDTH-1:1]};

`ifdef SERIAL_SUB_OVF_EN
    logic a_msb_q, b_msb_q, ovf_q;
    assign ovf_o = ovf_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            zero_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        a_q     <= a_i;
                        b_q     <= b_i;
                        br_q    <= bin_i;
                        r_q     <= '0;
                        cnt_q   <= '0;
                        ready_q <= 1'b0;
                        state_q <= RUN;
`ifdef SERIAL_SUB_OVF_EN
                        a_msb_q <= a_i[WIDTH-1];
                        b_msb_q <= b_i[WIDTH-1];
`endif
                    end
                end
                RUN: begin
                    a_q   <= a_q >> 1;
                    b_q   <= b_q >> 1;
                    br_q  <= br_d;
                    r_q   <= res_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        diff_q  <= res_d;
                        bout_q  <= br_d;
                        zero_q  <= (res_d == '0);
                        done_q  <= 1'b1;
                        state_q <= DONE;
`ifdef SERIAL_SUB_OVF_EN
                        ovf_q   <= (a_msb_q != b_msb_q) && (bit_d != a_msb_q);
`endif
                    end
                end
                DONE: begin
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ready_o = ready_q;
    assign done_o  = done_q;
    assign diff_o  = diff_q;
    assign bout_o  = bout_q;
    assign zero_o  = zero_q;
endmodule
